count_display_drv: RTL and testbench

COUNT_DISPLAY_DRV -- requirements
Module: count_display_drv

---
 rtl/count_display_pkg.sv | 28 ++
 rtl/count_display_drv_bin2bcd_seq.sv | 81 ++++++++
 rtl/count_display_drv.sv | 79 +++++++
 tb/tb_count_display_drv.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// Shared definitions for the count display driver: converter states, the
// active-low seven-segment table and the blank code.
package count_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam int DEFAULT_REFRESH_DIV = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment patterns {g,f,e,d,c,b,a}, active-low; element 0 is the digit 0
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] pattern;
    if (digit > 4'd9) pattern = SEG_BLANK;
    else              pattern = SEG_TABLE[digit];
    return pattern;
  endfunction

endpackage

// File: rtl/count_display_drv_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, publishes the
// result on bcd only once all eight shifts are complete.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        busy
);

  conv_state_t state, state_next;

  logic [7:0]  cap;
  logic [7:0]  cap_work;
  logic [11:0] bcd_work;
  logic [11:0] bcd_adj;
  logic [2:0]  iter;

  function automatic logic [3:0] add3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bin != cap) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (iter == 3'd7) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bcd_adj = {add3(bcd_work[11:8]), add3(bcd_work[7:4]), add3(bcd_work[3:0])};

  // The working registers are private; bcd only ever sees a finished result
  always_ff @(posedge clk) begin
    if (reset) begin
      cap      <= 8'd0;
      cap_work <= 8'd0;
      bcd_work <= 12'd0;
      iter     <= 3'd0;
      bcd      <= 12'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bin != cap) begin
            cap      <= bin;
            cap_work <= bin;
            bcd_work <= 12'd0;
            iter     <= 3'd0;
          end
        end
        ST_SHIFT: begin
          {bcd_work, cap_work} <= {bcd_adj, cap_work} << 1;
          iter                 <= iter + 3'd1;
        end
        ST_DONE: begin
          bcd <= bcd_work;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/count_display_drv.sv
// Converts the counter value to BCD and multiplexes it onto a three-digit
// active-low seven-segment display with leading-zero blanking.
module count_display_drv
  import count_display_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  count,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] presc;
  logic [1:0]    digit_idx;
  logic [2:0]    an_next;
  logic [6:0]    seg_next;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .bin   (count),
    .bcd   (bcd),
    .busy  (busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      digit_idx <= 2'd0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc     <= '0;
      digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // An inner zero (e.g. 105) stays lit because tens only blanks with hundreds
  always_comb begin
    an_next  = 3'b111;
    seg_next = SEG_BLANK;
    case (digit_idx)
      2'd0: begin
        an_next  = 3'b110;
        seg_next = seg_encode(bcd[3:0]);
      end
      2'd1: begin
        if (bcd[11:8] != 4'd0 || bcd[7:4] != 4'd0) begin
          an_next  = 3'b101;
          seg_next = seg_encode(bcd[7:4]);
        end
      end
      2'd2: begin
        if (bcd[11:8] != 4'd0) begin
          an_next  = 3'b011;
          seg_next = seg_encode(bcd[11:8]);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= 3'b110;
      seg <= SEG_TABLE[0];
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_count_display_drv.sv
// Scoreboard bench for count_display_drv: stimulus queues expected results,
// independent monitors compare conversions and display scan slots.
module tb_count_display_drv;

  localparam int REFRESH_DIV = 4;
  localparam int SLOTS       = 3 * REFRESH_DIV;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  count = 8'd0;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [11:0] bcd;
  logic        busy;

  typedef struct {
    logic [11:0] bcd;
    int          len;
  } conv_exp_t;

  typedef struct {
    logic [2:0] an;
    logic [6:0] seg;
  } scan_exp_t;

  conv_exp_t conv_q[$];
  scan_exp_t scan_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int k           = 0;
  logic reset_q   = 1'b1;

  count_display_drv #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .seg   (seg),
    .an    (an),
    .bcd   (bcd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge, and the reset level the DUT last sampled
  always @(posedge clk) begin
    reset_q <= reset;
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  // Conversion monitor: checks bcd stability while busy, then result and busy length
  logic        prev_busy = 1'b0;
  int          busy_len  = 0;
  logic [11:0] rise_bcd  = 12'd0;
  conv_exp_t   cexp;

  always @(negedge clk) begin
    if (reset_q) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (busy) begin
        if (!prev_busy) begin
          busy_len = 1;
          rise_bcd = bcd;
        end else begin
          busy_len++;
          vectors++;
          if (bcd !== rise_bcd) begin
            miscompares++;
            $display("[TB] FAIL bcd_hold: got 0x%03h, expected 0x%03h", bcd, rise_bcd);
          end
        end
      end else if (prev_busy) begin
        if (conv_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_completion: got bcd 0x%03h, expected none", bcd);
        end else begin
          cexp = conv_q.pop_front();
          vectors++;
          if (bcd !== cexp.bcd) begin
            miscompares++;
            $display("[TB] FAIL conv_bcd: got 0x%03h, expected 0x%03h", bcd, cexp.bcd);
          end
          vectors++;
          if (busy_len != cexp.len) begin
            miscompares++;
            $display("[TB] FAIL busy_len: got %0d, expected %0d", busy_len, cexp.len);
          end
        end
      end
      prev_busy = busy;
    end
  end

  // Scan monitor: one expected {an,seg} per cycle while entries are queued
  scan_exp_t sexp;

  always @(negedge clk) begin
    if (scan_q.size() > 0) begin
      sexp = scan_q.pop_front();
      vectors++;
      if (an !== sexp.an || seg !== sexp.seg) begin
        miscompares++;
        $display("[TB] FAIL scan: got an=%b seg=0x%02h, expected an=%b seg=0x%02h",
                 an, seg, sexp.an, sexp.seg);
      end
    end
  end

  function automatic logic [11:0] expected_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [11:0] actual,
                             input logic [11:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h", name, actual, expected);
    end
  endtask

  task automatic waitConversions();
    int n = 0;
    while (conv_q.size() > 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (conv_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL conv_timeout: got %0d pending, expected 0", conv_q.size());
      conv_q.delete();
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value, input logic [11:0] exp_bcd);
    @(posedge clk);
    #1;
    count = value;
    conv_q.push_back('{bcd: exp_bcd, len: 9});
    waitConversions();
  endtask

  task automatic checkScan(input logic [2:0] a0, input logic [6:0] s0,
                           input logic [2:0] a1, input logic [6:0] s1,
                           input logic [2:0] a2, input logic [6:0] s2);
    int n = 0;
    @(posedge clk);
    #1;
    while (((k - 1) % SLOTS) != 0 && n < 2 * SLOTS) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (((k - 1) % SLOTS) != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scan_align: got k=%0d, expected slot start", k);
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        scan_exp_t s;
        case (i / REFRESH_DIV)
          0:       s = '{an: a0, seg: s0};
          1:       s = '{an: a1, seg: s1};
          default: s = '{an: a2, seg: s2};
        endcase
        scan_q.push_back(s);
      end
      n = 0;
      while (scan_q.size() > 0 && n < 3 * SLOTS) begin
        @(posedge clk);
        n++;
      end
      #1;
    end
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with count=0
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_seg", 12'(seg), 12'h040);
    checkOutput("reset_an", 12'(an), 12'h006);
    checkOutput("reset_bcd", bcd, 12'h000);
    checkOutput("reset_busy", 12'(busy), 12'h000);
    reset = 1'b0;
    checkScan(3'b110, 7'h40, 3'b111, 7'h7F, 3'b111, 7'h7F);

    // Full-scale value
    applyStimulus(8'd255, 12'h255);
    checkScan(3'b110, 7'h12, 3'b101, 7'h12, 3'b011, 7'h24);

    // Single digit with both upper digits blanked
    applyStimulus(8'd7, 12'h007);
    checkScan(3'b110, 7'h78, 3'b111, 7'h7F, 3'b111, 7'h7F);

    // Inner zero stays lit
    applyStimulus(8'd105, 12'h105);
    checkScan(3'b110, 7'h12, 3'b101, 7'h40, 3'b011, 7'h79);

    // Input changes mid-conversion; the later value follows the first result
    @(posedge clk);
    #1;
    count = 8'd100;
    conv_q.push_back('{bcd: 12'h100, len: 9});
    conv_q.push_back('{bcd: 12'h101, len: 9});
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    count = 8'd101;
    waitConversions();
    checkOutput("bcd_after_change", bcd, 12'h101);

    // Reset mid-conversion, then restart from the held input
    @(posedge clk);
    #1;
    count = 8'd200;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_bcd", bcd, 12'h000);
    checkOutput("abort_busy", 12'(busy), 12'h000);
    reset = 1'b0;
    conv_q.push_back('{bcd: 12'h200, len: 9});
    repeat (9) @(posedge clk);
    #1;
    checkOutput("restart_edge9", bcd, 12'h000);
    @(posedge clk);
    #1;
    checkOutput("restart_edge10", bcd, 12'h200);
    waitConversions();

    // Up/down sweep
    for (int c = 0; c <= 255; c++) applyStimulus(8'(c), expected_bcd(c));
    for (int c = 254; c >= 0; c--) applyStimulus(8'(c), expected_bcd(c));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
